// File: rtl/instr_dispatcher.sv
// instr_dispatcher: accepts one instruction word, launches the matching FSM for one cycle, waits for its done, retires it
// Ports: clock, reset (asynchronous, active-high); instr_valid/instr/instr_ready accept handshake;
// fsm_done per-opcode done inputs; FSM_start one-cycle launch code; source/dest fields latched on accept;
// busy (not IDLE), retired, err_illegal, err_timeout status pulses.
// Define DISPATCH_WATCHDOG_EN to build the WAIT-state watchdog; otherwise err_timeout is tied 0.
module instr_dispatcher #(
  parameter logic [15:0] OP_MASK = 16'h0FFE,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  input  logic [15:0] fsm_done,
  output logic [3:0]  FSM_start,
  output logic [5:0]  source,
  output logic [5:0]  dest,
  output logic        busy,
  output logic        retired,
  output logic        err_illegal,
  output logic        err_timeout
);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, RETIRE, ERR} state_t;
  state_t state;
  logic [3:0] op;
  logic [3:0] opc;
  assign opc = instr[15:12];
  assign instr_ready = state == IDLE;
`ifdef DISPATCH_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt;
`else
  assign err_timeout = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      op <= 4'd0;
      source <= 6'd0;
      dest <= 6'd0;
      FSM_start <= 4'd0;
      busy <= 1'b0;
      retired <= 1'b0;
      err_illegal <= 1'b0;
`ifdef DISPATCH_WATCHDOG_EN
      cnt <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      FSM_start <= 4'd0;
      retired <= 1'b0;
      err_illegal <= 1'b0;
`ifdef DISPATCH_WATCHDOG_EN
      err_timeout <= 1'b0;
`endif
      case (state)
        IDLE:
          if (instr_valid) begin
            op <= opc;
            source <= instr[5:0];
            dest <= instr[11:6];
            busy <= 1'b1;
            // opcode 0 is a NOP even if its mask bit happens to be set
            if (opc == 4'd0) begin
              state <= RETIRE;
              retired <= 1'b1;
            end else if (!OP_MASK[opc]) begin
              state <= ERR;
              err_illegal <= 1'b1;
            end else begin
              state <= LAUNCH;
              FSM_start <= opc;
            end
          end
        LAUNCH: begin
          state <= WAIT;
`ifdef DISPATCH_WATCHDOG_EN
          cnt <= '0;
`endif
        end
        WAIT:
          // done is checked first so a done on the last allowed cycle beats the watchdog
          if (fsm_done[op]) begin
            state <= RETIRE;
            retired <= 1'b1;
          end
`ifdef DISPATCH_WATCHDOG_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state <= IDLE;
            busy <= 1'b0;
            err_timeout <= 1'b1;
          end else cnt <= cnt + 1'b1;
`endif
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_instr_dispatcher.sv
// tb_instr_dispatcher: randomized requester/responder bench with a cycle-indexed expectation schedule
module tb_instr_dispatcher;
  localparam int N = 20000;
  localparam logic [15:0] MASK = 16'h0FFE;
  localparam int T = 32;
`ifdef DISPATCH_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic instr_valid = 1'b0;
  logic [15:0] instr = 16'd0;
  logic [15:0] fsm_done = 16'd0;
  logic instr_ready, busy, retired, err_illegal, err_timeout;
  logic [3:0] FSM_start;
  logic [5:0] source, dest;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit e_rdy [N];
  logic [3:0] e_start [N];
  bit e_ret [N];
  bit e_ill [N];
  bit e_to [N];
  bit acc [N];
  logic [5:0] acc_src [N];
  logic [5:0] acc_dst [N];
  logic [5:0] m_src = 6'd0;
  logic [5:0] m_dst = 6'd0;
  int lk_mov = -100, lk_nop = -100, lk_ill = -100, lk_to = -100, lk_last = -100, dummy;

  instr_dispatcher dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .fsm_done(fsm_done), .FSM_start(FSM_start),
    .source(source), .dest(dest), .busy(busy), .retired(retired),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clock)
    if (reset) begin
      m_src = 6'd0;
      m_dst = 6'd0;
    end else if (cyc >= 1 && cyc < N) begin
      if (acc[cyc-1]) begin
        m_src = acc_src[cyc-1];
        m_dst = acc_dst[cyc-1];
      end
      chk($sformatf("cycle %0d {ready,busy,start,src,dst,ret,ill,to}", cyc),
          32'({instr_ready, busy, FSM_start, source, dest, retired, err_illegal, err_timeout}),
          32'({e_rdy[cyc], !e_rdy[cyc], e_start[cyc], m_src, m_dst, e_ret[cyc], e_ill[cyc], e_to[cyc]}));
    end

  always @(negedge clock)
    if (!reset) begin
      if (cyc == lk_mov + 1) chk("mov launch", 32'({FSM_start, source, dest}), 32'({4'b1000, 6'd5, 6'd5}));
      if (cyc == lk_mov + 2) chk("mov start single cycle", 32'(FSM_start), 32'd0);
      if (cyc == lk_mov + 7) chk("mov retired", 32'({retired, instr_ready}), 32'b10);
      if (cyc == lk_mov + 8) chk("mov ready again", 32'({retired, instr_ready}), 32'b01);
      if (cyc == lk_nop + 1) chk("nop retire", 32'({FSM_start, retired, instr_ready}), 32'({4'd0, 1'b1, 1'b0}));
      if (cyc == lk_nop + 2) chk("nop ready", 32'(instr_ready), 32'd1);
      if (cyc == lk_ill + 1) chk("illegal pulse", 32'({FSM_start, err_illegal, retired}), 32'({4'd0, 1'b1, 1'b0}));
      if (cyc == lk_ill + 2) chk("illegal ready", 32'({err_illegal, instr_ready}), 32'b01);
`ifdef DISPATCH_WATCHDOG_EN
      if (cyc == lk_to + 33) chk("timeout last wait", 32'({busy, err_timeout}), 32'b10);
      if (cyc == lk_to + 34) chk("timeout pulse", 32'({busy, instr_ready, err_timeout, retired}), 32'b0110);
      if (cyc == lk_last + 34) chk("done on last wait", 32'({retired, err_timeout}), 32'b10);
`endif
    end

  task automatic issue(input logic [15:0] w, input int d, input bit hold, input int gap, output int k);
    int lo, hi, dc, endc, g;
    logic [3:0] op;
    op = w[15:12];
    lo = 0;
    hi = -1;
    dc = -1;
    g = gap;
    while (!e_rdy[cyc] || g > 0) begin
      if (e_rdy[cyc]) g--;
      instr_valid = 1'b0;
      fsm_done = 16'($urandom);
      @(posedge clock);
      #2;
    end
    k = cyc;
    instr_valid = 1'b1;
    instr = w;
    acc[k] = 1'b1;
    acc_src[k] = w[5:0];
    acc_dst[k] = w[11:6];
    if (op == 4'd0) begin
      e_rdy[k+1] = 1'b0;
      e_ret[k+1] = 1'b1;
      endc = k + 2;
    end else if (!MASK[op]) begin
      e_rdy[k+1] = 1'b0;
      e_ill[k+1] = 1'b1;
      endc = k + 2;
    end else begin
      e_start[k+1] = op;
      lo = k + 2;
      if (WD && d >= T) begin
        hi = k + 1 + T;
        endc = k + 2 + T;
        e_to[endc] = 1'b1;
      end else begin
        dc = k + 2 + d;
        hi = dc;
        endc = dc + 2;
        e_ret[dc+1] = 1'b1;
      end
      for (int i = k + 1; i < endc; i++) e_rdy[i] = 1'b0;
    end
    do begin
      @(posedge clock);
      #2;
      fsm_done = 16'($urandom);
      if (cyc >= lo && cyc <= hi) begin
        fsm_done[3] = 1'b1;
        fsm_done[op] = (cyc == dc);
      end
      instr_valid = cyc >= endc ? 1'b0 : (hold | 1'($urandom));
      instr = 16'($urandom);
    end while (cyc < endc);
  endtask

  task automatic reset_mid(input logic [15:0] w, input int n);
    int k;
    while (!e_rdy[cyc]) begin
      @(posedge clock);
      #2;
    end
    k = cyc;
    instr_valid = 1'b1;
    instr = w;
    acc[k] = 1'b1;
    acc_src[k] = w[5:0];
    acc_dst[k] = w[11:6];
    e_start[k+1] = w[15:12];
    for (int i = k + 1; i <= k + n; i++) e_rdy[i] = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #2;
      instr_valid = 1'b0;
      fsm_done = 16'd0;
    end
    #1 reset = 1'b1;
    #1;
    chk("async reset clears", 32'({busy, FSM_start, source, dest, retired, instr_ready}),
        32'({1'b0, 4'd0, 6'd0, 6'd0, 1'b0, 1'b1}));
    @(posedge clock);
    #2 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL bench timeout: no finish reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      e_rdy[i] = 1'b1;
      e_start[i] = 4'd0;
      e_ret[i] = 1'b0;
      e_ill[i] = 1'b0;
      e_to[i] = 1'b0;
      acc[i] = 1'b0;
      acc_src[i] = 6'd0;
      acc_dst[i] = 6'd0;
    end
    #1 reset = 1'b1;
    #2;
    chk("reset state", 32'({instr_ready, busy, FSM_start, source, dest, retired, err_illegal, err_timeout}),
        32'({1'b1, 1'b0, 4'd0, 6'd0, 6'd0, 3'd0}));
    @(posedge clock);
    #2 reset = 1'b0;
    issue(16'h8145, 4, 1'b1, 0, lk_mov);
    issue(16'h0000, 0, 1'b0, 0, lk_nop);
    issue(16'hF000, 0, 1'b0, 1, lk_ill);
    issue(16'h3A5C, T, 1'b1, 0, lk_to);
    issue(16'h5123, T - 1, 1'b0, 0, lk_last);
    for (int t = 0; t < 300 && cyc < N - 200; t++)
      issue(16'($urandom), int'($urandom_range(0, WD ? T + 2 : 40)), 1'($urandom), int'($urandom_range(0, 2)), dummy);
    reset_mid(16'h7044, 5);
    reset_mid(16'h2FFF, 1);
    issue(16'h0041, 0, 1'b0, 1, dummy);
    issue(16'h9ABC, 2, 1'b1, 0, dummy);
    repeat (3) @(posedge clock);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
